chan_fetch: RTL and testbench

//  Sample fetch stage directly downstream of the channel controller. Assembles the 3-byte
//  per-channel sample address (addrhi, addrmid, addrlo) from the controller byte stream,

---
 rtl/chan_pkg.sv | 20 ++
 rtl/chan_addr_fifo.sv | 46 ++++
 rtl/chan_fetch.sv | 147 ++++++++++++++
 tb/tb_chan_fetch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/chan_pkg.sv
// Constants shared by the channel controller, the sample fetch stage and the mixer.
package chan_pkg;

  localparam int AW = 22;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    EMIT = 2'd3
  } fetch_state_e;

  // Order of the three address bytes in the controller stream.
  typedef enum logic [1:0] {
    BYTE_HI  = 2'd0,
    BYTE_MID = 2'd1,
    BYTE_LO  = 2'd2
  } addr_byte_e;

endpackage

// File: rtl/chan_addr_fifo.sv
// Small address FIFO between the byte assembler and the fetch FSM.
module chan_addr_fifo #(
  parameter int W       = 22,
  parameter int DEPTH_L = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int DEPTH = 1 << DEPTH_L;

  logic [W-1:0]       mem_q [DEPTH];
  logic [DEPTH_L-1:0] wptr_q, rptr_q;
  logic [DEPTH_L:0]   cnt_q;
  logic               do_push, do_pop;

  assign full_o     = (cnt_q == (DEPTH_L+1)'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign do_pop     = pop_i && !empty_o;
  // A pop in the same cycle frees a slot, so a push into a full queue still lands.
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + {{DEPTH_L{1'b0}}, do_push} - {{DEPTH_L{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/chan_fetch.sv
// Sample fetch stage: assembles channel addresses, queues them, reads sample bytes, emits pairs.
// CHAN_FETCH_INTERP_EN: read addr and addr+1 per channel; otherwise a single read, byte duplicated.
module chan_fetch #(
  parameter int AW       = chan_pkg::AW,
  parameter int QDEPTH_L = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sync_stb,
  input  logic [7:0]    in_data,
  input  logic          in_stb_addr,
  output logic [AW-1:0] mem_addr,
  output logic          mem_req,
  input  logic          mem_ack,
  input  logic [7:0]    mem_rdata,
  output logic [15:0]   smp_data,
  output logic          smp_stb,
  output logic          ovf
);

  import chan_pkg::*;

  addr_byte_e    bcnt_q, bcnt_eff;
  logic [5:0]    hi_q;
  logic [7:0]    mid_q;
  logic [21:0]   asm_addr;
  logic          push, pop, q_full, q_empty;
  logic [AW-1:0] q_data;

  fetch_state_e  state_q;
  logic [AW-1:0] mem_addr_q;
  logic          mem_req_q, smp_stb_q, ovf_q;
  logic [7:0]    smp0_q;
  logic [15:0]   smp_data_q;
`ifdef CHAN_FETCH_INTERP_EN
  logic [7:0]    smp1_q;
`endif

  // A byte arriving with sync_stb is always the hi byte of a fresh address.
  assign bcnt_eff = sync_stb ? BYTE_HI : bcnt_q;
  assign push     = in_stb_addr && (bcnt_eff == BYTE_LO);
  assign asm_addr = {hi_q, mid_q, in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q <= BYTE_HI;
      hi_q   <= '0;
      mid_q  <= '0;
    end else if (in_stb_addr) begin
      case (bcnt_eff)
        BYTE_HI: begin
          hi_q   <= in_data[5:0];
          bcnt_q <= BYTE_MID;
        end
        BYTE_MID: begin
          mid_q  <= in_data;
          bcnt_q <= BYTE_LO;
        end
        default: bcnt_q <= BYTE_HI;
      endcase
    end else if (sync_stb) begin
      bcnt_q <= BYTE_HI;
    end
  end

  chan_addr_fifo #(
    .W       (AW),
    .DEPTH_L (QDEPTH_L)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (AW'(asm_addr)),
    .pop_i       (pop),
    .pop_data_o  (q_data),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  assign pop = (state_q == IDLE) && !q_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      smp0_q     <= '0;
`ifdef CHAN_FETCH_INTERP_EN
      smp1_q     <= '0;
`endif
      smp_data_q <= '0;
      smp_stb_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      smp_stb_q <= 1'b0;
      if (push && q_full && !pop) ovf_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (!q_empty) begin
            mem_addr_q <= q_data;
            mem_req_q  <= 1'b1;
            state_q    <= RD0;
          end
        end
        RD0: begin
          if (mem_ack) begin
            smp0_q <= mem_rdata;
`ifdef CHAN_FETCH_INTERP_EN
            // req stays high; only the address moves on to the second byte
            mem_addr_q <= mem_addr_q + AW'(1);
            state_q    <= RD1;
`else
            mem_req_q <= 1'b0;
            state_q   <= EMIT;
`endif
          end
        end
`ifdef CHAN_FETCH_INTERP_EN
        RD1: begin
          if (mem_ack) begin
            smp1_q    <= mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= EMIT;
          end
        end
`endif
        EMIT: begin
          smp_stb_q <= 1'b1;
`ifdef CHAN_FETCH_INTERP_EN
          smp_data_q <= {smp1_q, smp0_q};
`else
          smp_data_q <= {smp0_q, smp0_q};
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_req  = mem_req_q;
  assign smp_data = smp_data_q;
  assign smp_stb  = smp_stb_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_chan_fetch.sv
// Directed bench for chan_fetch: vector table plus sequences for overflow, resync and reset.
module tb_chan_fetch;

`ifdef CHAN_FETCH_INTERP_EN
  localparam bit INTERP = 1'b1;
`else
  localparam bit INTERP = 1'b0;
`endif
  localparam int LAT = INTERP ? 5 : 4;
  localparam int NRD = INTERP ? 2 : 1;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        sync_stb = 1'b0, in_stb_addr = 1'b0;
  logic [7:0]  in_data = 8'h00, mem_rdata = 8'h00;
  logic        mem_ack = 1'b0;
  logic [21:0] mem_addr;
  logic        mem_req, smp_stb, ovf;
  logic [15:0] smp_data;

  int n_vec = 0, n_err = 0;
  int wst = 0;
  logic [21:0] alog[$];
  logic [15:0] slog[$];

  always #5 clk = ~clk;

  chan_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sync_stb    (sync_stb),
    .in_data     (in_data),
    .in_stb_addr (in_stb_addr),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .smp_data    (smp_data),
    .smp_stb     (smp_stb),
    .ovf         (ovf)
  );

  function automatic logic [7:0] mem_byte(input logic [21:0] a);
    return a[7:0];
  endfunction

  function automatic logic [15:0] pair(input logic [21:0] a);
    logic [21:0] a1;
    a1 = a + 22'd1;
    return INTERP ? {mem_byte(a1), mem_byte(a)} : {mem_byte(a), mem_byte(a)};
  endfunction

  function automatic logic [21:0] qget(input int idx);
    if (idx >= 0 && idx < alog.size()) return alog[idx];
    return 22'bx;
  endfunction

  // Memory: acks after wst wait cycles, counting afresh whenever the address changes.
  bit          m_act = 1'b0;
  logic [21:0] m_cur = '0;
  int          m_wcnt = 0;
  always @(negedge clk) begin
    if (!mem_req) begin
      m_act   = 1'b0;
      mem_ack = 1'b0;
    end else begin
      if (!m_act || mem_addr !== m_cur) begin
        m_act  = 1'b1;
        m_cur  = mem_addr;
        m_wcnt = 0;
      end
      mem_ack   = (m_wcnt == wst);
      mem_rdata = mem_ack ? mem_byte(mem_addr) : 8'h00;
      m_wcnt++;
    end
  end

  always @(posedge clk) begin
    if (mem_req && mem_ack) alog.push_back(mem_addr);
    if (smp_stb) slog.push_back(smp_data);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] b, input bit s);
    @(posedge clk); #1;
    in_data = b; in_stb_addr = 1'b1; sync_stb = s;
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_stb_addr = 1'b0; sync_stb = 1'b0;
    end
  endtask

  task automatic wait_stb(input int n, input int bound);
    int k = 0;
    while (slog.size() < n && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  // Six addresses back to back; w picks whether the FSM pops exactly at the sixth push.
  task automatic burst(input string tag, input int w, input int exp_n, input logic exp_ovf);
    logic [21:0] a;
    wst = w; alog.delete(); slog.delete();
    for (int j = 0; j < 6; j++) begin
      put(8'h0A, 1'b0);
      put(8'(j), 1'b0);
      if (j == 5) chk({tag, "_ovf_pre"}, ovf, 0);
      put(8'(j*16 + 1), 1'b0);
    end
    quiet(1);
    wait_stb(exp_n, 600);
    quiet(40);
    chk({tag, "_nstb"}, slog.size(), exp_n);
    for (int j = 0; j < exp_n; j++) begin
      a = {6'h0A, 8'(j), 8'(j*16 + 1)};
      chk($sformatf("%s_data%0d", tag, j), (j < slog.size()) ? slog[j] : 16'hxxxx, pair(a));
    end
    chk({tag, "_ovf"}, ovf, exp_ovf);
  endtask

  typedef struct {
    logic [7:0]  hi, mid, lo;
    int          ws;
    logic [21:0] a0, a1;
    logic [15:0] d;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[4];
    int   k;
    vt[0] = '{8'h01, 8'h23, 8'h45, 0, 22'h012345, 22'h012346, INTERP ? 16'h4645 : 16'h4545};
    vt[1] = '{8'hFF, 8'hFF, 8'hFF, 0, 22'h3FFFFF, 22'h000000, INTERP ? 16'h00FF : 16'hFFFF};
    vt[2] = '{8'hC7, 8'h00, 8'h10, 0, 22'h070010, 22'h070011, INTERP ? 16'h1110 : 16'h1010};
    vt[3] = '{8'h12, 8'h34, 8'h56, 2, 22'h123456, 22'h123457, INTERP ? 16'h5756 : 16'h5656};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_stb", smp_stb, 0);
    chk("rst_data", smp_data, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    quiet(3);
    chk("idle_req", mem_req, 0);

    for (int i = 0; i < 4; i++) begin
      wst = vt[i].ws; alog.delete(); slog.delete();
      put(vt[i].hi, 1'b0); put(vt[i].mid, 1'b0); put(vt[i].lo, 1'b0);
      k = 0;
      while (k == 0 || (!smp_stb && k < 100)) begin
        @(posedge clk); #1;
        in_stb_addr = 1'b0;
        k++;
      end
      chk($sformatf("v%0d_lat", i), k, LAT + vt[i].ws * NRD);
      chk($sformatf("v%0d_data", i), smp_data, vt[i].d);
      @(posedge clk); #1;
      chk($sformatf("v%0d_stb_1cyc", i), smp_stb, 0);
      quiet(3);
      chk($sformatf("v%0d_addr0", i), qget(0), vt[i].a0);
      chk($sformatf("v%0d_nrd", i), alog.size(), NRD);
      chk($sformatf("v%0d_addrN", i), qget(alog.size() - 1), INTERP ? vt[i].a1 : vt[i].a0);
    end

    burst("full_pp", INTERP ? 5 : 11, 6, 1'b0);
    burst("full_drop", INTERP ? 6 : 12, 5, 1'b1);

    wst = 0; alog.delete(); slog.delete();
    put(8'h77, 1'b0); put(8'h66, 1'b0);
    @(posedge clk); #1;
    in_stb_addr = 1'b0; sync_stb = 1'b1;
    put(8'h00, 1'b0); put(8'h10, 1'b0); put(8'h20, 1'b0);
    quiet(1); wait_stb(1, 50); quiet(5);
    chk("sync_nstb", slog.size(), 1);
    chk("sync_addr", qget(0), 22'h001020);

    alog.delete(); slog.delete();
    put(8'h55, 1'b0); put(8'h01, 1'b1); put(8'h02, 1'b0); put(8'h03, 1'b0);
    quiet(1); wait_stb(1, 50); quiet(5);
    chk("synchi_nstb", slog.size(), 1);
    chk("synchi_addr", qget(0), 22'h010203);

    wst = 3; alog.delete(); slog.delete();
    put(8'h00, 1'b0); put(8'h01, 1'b0); put(8'h00, 1'b0);
    put(8'h00, 1'b0); put(8'h02, 1'b0); put(8'h00, 1'b0);
    quiet(1);
    k = 0;
    while (!(mem_req && alog.size() >= NRD - 1) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rst_mid_req_pre", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_addr", mem_addr, 0);
    chk("rst_mid_ovf", ovf, 0);
    alog.delete(); slog.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    quiet(40);
    chk("post_rst_nstb", slog.size(), 0);
    chk("post_rst_nrd", alog.size(), 0);
    chk("post_rst_req", mem_req, 0);

    wst = 0;
    put(8'h01, 1'b0); put(8'h23, 1'b0); put(8'h45, 1'b0);
    quiet(1); wait_stb(1, 50); quiet(3);
    chk("again_data", (slog.size() > 0) ? slog[0] : 16'hxxxx, INTERP ? 16'h4645 : 16'h4545);
    chk("again_nrd", alog.size(), NRD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
